// File: rtl/iddmm_pkg.sv
// Shared constants and elaboration helpers for the IDDMM multiplier.
// Also sizes the flattened adder-tree bus used by iddmm_mul_pipe.
package iddmm_pkg;

  localparam int DEF_WIDTH = 128;
  localparam int DEF_XW    = 24;
  localparam int DEF_YW    = 16;

  function automatic int clog2(input int n);
    int r;
    r = 0;
    while ((1 << r) < n) r++;
    return r;
  endfunction

  function automatic int ceil_div(input int a, input int b);
    return (a + b - 1) / b;
  endfunction

  // Leaf offset of tree level l in a bus packing all levels back to back.
  function automatic int tree_off(input int nl, input int l);
    int acc;
    acc = 0;
    for (int k = 0; k < l; k++)
      acc += ceil_div(nl, 1 << k);
    return acc;
  endfunction

endpackage

// File: rtl/iddmm_add_tree_stage.sv
// One registered pairwise-sum level of the partial-product adder tree.
// Valid and tag travel with the data; an odd leftover leaf passes through.
module iddmm_add_tree_stage
  import iddmm_pkg::*;
#(
  parameter int N           = 2,
  parameter int W           = 256,
  parameter int TAG_W       = 4,
  parameter bit RST_DATA    = 1'b0,
  localparam int NO         = ceil_div(N, 2)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en_i,
  input  logic             v_i,
  input  logic [TAG_W-1:0] tag_i,
  input  logic [N*W-1:0]   d_i,
  output logic             v_o,
  output logic [TAG_W-1:0] tag_o,
  output logic [NO*W-1:0]  q_o
);

  logic [NO*W-1:0]  sum_d;
  logic [NO*W-1:0]  sum_q;
  logic             v_q;
  logic [TAG_W-1:0] tag_q;

  always_comb begin
    sum_d = '0;
    for (int k = 0; k < N / 2; k++)
      sum_d[k*W +: W] = d_i[2*k*W +: W]
                      + d_i[(2*k+1)*W +: W];
    if (N % 2 == 1)
      sum_d[(NO-1)*W +: W] = d_i[(N-1)*W +: W];
  end

  always_ff @(posedge clk) begin
    if (rst)       v_q <= 1'b0;
    else if (en_i) v_q <= v_i;
  end

  // Only the final level feeds the outputs, so only it needs a data reset.
  always_ff @(posedge clk) begin
    if (rst && RST_DATA) begin
      sum_q <= '0;
      tag_q <= '0;
    end else if (en_i) begin
      sum_q <= sum_d;
      tag_q <= tag_i;
    end
  end

  assign v_o   = v_q;
  assign tag_o = tag_q;
  assign q_o   = sum_q;

endmodule

// File: rtl/iddmm_mul_pipe.sv
// Pipelined WIDTH x WIDTH multiplier with valid/ready stall and tag.
// IDDMM_MUL_ADD_EN adds the in_z addend as an extra tree leaf.
module iddmm_mul_pipe
  import iddmm_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int XW    = DEF_XW,
  parameter int YW    = DEF_YW,
  parameter int TAG_W = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [WIDTH-1:0]   in_x,
  input  logic [WIDTH-1:0]   in_y,
  input  logic [TAG_W-1:0]   in_tag,
`ifdef IDDMM_MUL_ADD_EN
  input  logic [2*WIDTH-1:0] in_z,
`endif
  output logic               out_valid,
  input  logic               out_ready,
  output logic [2*WIDTH-1:0] out_result,
  output logic [TAG_W-1:0]   out_tag
);

  localparam int W2 = 2 * WIDTH;
  localparam int NX = ceil_div(WIDTH, XW);
  localparam int NY = ceil_div(WIDTH, YW);
  localparam int NP = NX * NY;
`ifdef IDDMM_MUL_ADD_EN
  localparam int NL = NP + 1;
`else
  localparam int NL = NP;
`endif
  localparam int S   = clog2(NL);
  localparam int TOT = tree_off(NL, S + 1);

  logic stall;
  logic en;

  assign stall    = out_valid & ~out_ready;
  assign en       = ~stall;
  assign in_ready = en;

  logic [NX*XW-1:0]   x_ext;
  logic [NY*YW-1:0]   y_ext;
  logic [XW+YW-1:0]   pp;
  logic [NL*W2-1:0]   leaf_d;
  logic [NL*W2-1:0]   leaf_q;
  logic               v0_q;
  logic [TAG_W-1:0]   tag0_q;

  assign x_ext = (NX*XW)'(in_x);
  assign y_ext = (NY*YW)'(in_y);

  always_comb begin
    leaf_d = '0;
    pp     = '0;
    for (int i = 0; i < NX; i++) begin
      for (int j = 0; j < NY; j++) begin
        pp = (XW+YW)'(x_ext[i*XW +: XW])
           * (XW+YW)'(y_ext[j*YW +: YW]);
        leaf_d[(i*NY+j)*W2 +: W2] =
          W2'(pp) << (i*XW + j*YW);
      end
    end
`ifdef IDDMM_MUL_ADD_EN
    leaf_d[NP*W2 +: W2] = in_z;
`endif
  end

  always_ff @(posedge clk) begin
    if (rst)     v0_q <= 1'b0;
    else if (en) v0_q <= in_valid;
  end

  always_ff @(posedge clk) begin
    if (en) begin
      leaf_q <= leaf_d;
      tag0_q <= in_tag;
    end
  end

  // All tree levels packed back to back; level l starts at tree_off(NL,l).
  logic [TOT*W2-1:0]      tree;
  logic [S:0]             v;
  logic [S:0][TAG_W-1:0]  tg;

  assign tree[NL*W2-1:0] = leaf_q;
  assign v[0]            = v0_q;
  assign tg[0]           = tag0_q;

  for (genvar s = 0; s < S; s++) begin : g_tree
    localparam int NI   = ceil_div(NL, 1 << s);
    localparam int NO   = ceil_div(NL, 1 << (s + 1));
    localparam int OFFI = tree_off(NL, s);
    localparam int OFFO = tree_off(NL, s + 1);

    iddmm_add_tree_stage #(
      .N        (NI),
      .W        (W2),
      .TAG_W    (TAG_W),
      .RST_DATA (s == S - 1)
    ) u_stage (
      .clk   (clk),
      .rst   (rst),
      .en_i  (en),
      .v_i   (v[s]),
      .tag_i (tg[s]),
      .d_i   (tree[OFFI*W2 +: NI*W2]),
      .v_o   (v[s+1]),
      .tag_o (tg[s+1]),
      .q_o   (tree[OFFO*W2 +: NO*W2])
    );
  end

  assign out_valid  = v[S];
  assign out_tag    = tg[S];
  assign out_result = tree[(TOT-1)*W2 +: W2];

endmodule

// File: tb/tb_iddmm_mul_pipe.sv
// Directed and scoreboard checks for iddmm_mul_pipe (default parameters).
// Define IDDMM_MUL_ADD_EN to exercise the addend build.
module tb_iddmm_mul_pipe;
  import iddmm_pkg::*;

  localparam int WIDTH = 128;
  localparam int XW    = 24;
  localparam int YW    = 16;
  localparam int TAG_W = 4;
  localparam int W2    = 2 * WIDTH;
  localparam int NP    = ceil_div(WIDTH, XW) * ceil_div(WIDTH, YW);
`ifdef IDDMM_MUL_ADD_EN
  localparam int NL  = NP + 1;
  localparam bit ADD = 1'b1;
`else
  localparam int NL  = NP;
  localparam bit ADD = 1'b0;
`endif
  localparam int LAT = 1 + clog2(NL);

  localparam logic [WIDTH-1:0] MAX  = '1;
  localparam logic [WIDTH-1:0] ZW   = '0;
  localparam logic [W2-1:0]    Z2   = '0;
  localparam logic [W2-1:0]    ONES = '1;

  typedef struct packed {
    logic [W2-1:0]    r;
    logic [TAG_W-1:0] t;
  } exp_t;

  typedef struct {
    logic [WIDTH-1:0] x;
    logic [WIDTH-1:0] y;
    logic [W2-1:0]    z;
    logic [W2-1:0]    r;
  } vec_t;

  logic             clk = 1'b0;
  logic             rst;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_x;
  logic [WIDTH-1:0] in_y;
  logic [TAG_W-1:0] in_tag;
  logic [W2-1:0]    z_cur;
  logic             out_valid;
  logic             out_ready;
  logic [W2-1:0]    out_result;
  logic [TAG_W-1:0] out_tag;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  iddmm_mul_pipe #(
    .WIDTH (WIDTH),
    .XW    (XW),
    .YW    (YW),
    .TAG_W (TAG_W)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_x       (in_x),
    .in_y       (in_y),
    .in_tag     (in_tag),
`ifdef IDDMM_MUL_ADD_EN
    .in_z       (z_cur),
`endif
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_result (out_result),
    .out_tag    (out_tag)
  );

  function automatic logic [WIDTH-1:0] rnd_w();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  function automatic logic [W2-1:0] golden();
    return W2'(in_x) * W2'(in_y) + z_cur;
  endfunction

  task automatic drive(input logic v, input logic [WIDTH-1:0] x,
                       input logic [WIDTH-1:0] y, input logic [W2-1:0] z,
                       input logic [TAG_W-1:0] t);
    in_valid = v;
    in_x     = x;
    in_y     = y;
    z_cur    = z;
    in_tag   = t;
  endtask

  task automatic test_reset();
    rst       = 1'b1;
    out_ready = 1'b1;
    drive(1'b0, ZW, ZW, Z2, '0);
    repeat (3) @(negedge clk);
    checks++;
    if (out_valid !== 1'b0) begin
      failures++;
      $display("FAIL reset_valid got=%b exp=0", out_valid);
    end
    checks++;
    if (out_result !== Z2 || out_tag !== '0) begin
      failures++;
      $display("FAIL reset_data got=%h/%h exp=0/0", out_result, out_tag);
    end
    rst = 1'b0;
    @(negedge clk);
    checks++;
    if (in_ready !== 1'b1) begin
      failures++;
      $display("FAIL reset_ready got=%b exp=1", in_ready);
    end
  endtask

  task automatic test_basic();
    int n;
    out_ready = 1'b1;
    drive(1'b1, 128'h3, 128'h5, Z2, 4'h2);
    @(negedge clk);
    in_valid = 1'b0;
    n = 1;
    while (!out_valid && n < LAT + 4) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (out_valid !== 1'b1 || n != LAT) begin
      failures++;
      $display("FAIL basic_latency got=%0d exp=%0d", n, LAT);
    end
    checks++;
    if (out_result !== 256'hF || out_tag !== 4'h2) begin
      failures++;
      $display("FAIL basic_result got=%h/%h exp=f/2", out_result, out_tag);
    end
    @(negedge clk);
    checks++;
    if (out_valid !== 1'b0) begin
      failures++;
      $display("FAIL basic_single got=%b exp=0", out_valid);
    end
  endtask

  task automatic test_directed();
    vec_t tv[$];
    tv.push_back('{ZW, MAX, Z2, Z2});
    tv.push_back('{128'h1, MAX, Z2, {ZW, MAX}});
    tv.push_back('{128'h1_0000_0000_0000_0000, 128'h1_0000_0000_0000_0000,
                   Z2, {128'h1, ZW}});
    tv.push_back('{128'h8000_0000_0000_0000_0000_0000_0000_0000, 128'h2,
                   Z2, {128'h1, ZW}});
    tv.push_back('{128'hFFFF, 128'h1_0000, Z2, 256'hFFFF_0000});
    tv.push_back('{128'h100_0000, 128'h1_0000, Z2, 256'h100_0000_0000});
    tv.push_back('{128'hFF_FFFF, 128'hFFFF, Z2, 256'hFF_FEFF_0001});
    tv.push_back('{MAX, 128'h2, Z2,
                   {128'h1, 128'hFFFF_FFFF_FFFF_FFFF_FFFF_FFFF_FFFF_FFFE}});
    tv.push_back('{MAX, MAX, Z2,
                   {128'hFFFF_FFFF_FFFF_FFFF_FFFF_FFFF_FFFF_FFFE, 128'h1}});
    if (ADD) begin
      tv.push_back('{MAX, MAX,
                     {128'h1, 128'hFFFF_FFFF_FFFF_FFFF_FFFF_FFFF_FFFF_FFFE},
                     ONES});
      tv.push_back('{MAX, MAX,
                     {128'h1, MAX}, Z2});
      tv.push_back('{ZW, ZW, ONES, ONES});
    end
    out_ready = 1'b1;
    foreach (tv[k]) begin
      int n;
      drive(1'b1, tv[k].x, tv[k].y, tv[k].z, TAG_W'(k));
      @(negedge clk);
      in_valid = 1'b0;
      n = 1;
      while (!out_valid && n < LAT + 4) begin
        @(negedge clk);
        n++;
      end
      checks++;
      if (out_valid !== 1'b1 || out_result !== tv[k].r ||
          out_tag !== TAG_W'(k)) begin
        failures++;
        $display("FAIL directed[%0d] got=%b/%h/%h exp=1/%h/%h", k,
                 out_valid, out_result, out_tag, tv[k].r, TAG_W'(k));
      end
      @(negedge clk);
    end
  endtask

  task automatic test_back_to_back();
    localparam int N = 400;
    exp_t q[$];
    exp_t e;
    int sent = 0;
    int got = 0;
    int first_c = -1;
    int last_c = -1;
    out_ready = 1'b1;
    for (int c = 0; c < N + LAT + 20 && (sent < N || q.size() > 0); c++) begin
      if (sent < N)
        drive(1'b1, (sent % 7 == 0) ? MAX : rnd_w(),
              (sent % 5 == 0) ? MAX : rnd_w(),
              ADD ? {rnd_w(), rnd_w()} : Z2, TAG_W'(sent));
      else
        in_valid = 1'b0;
      #1;
      if (out_valid) begin
        if (first_c < 0) first_c = c;
        last_c = c;
        got++;
        checks++;
        if (q.size() == 0) begin
          failures++;
          $display("FAIL b2b_extra got=%h exp=none", out_result);
        end else begin
          e = q.pop_front();
          if (out_result !== e.r || out_tag !== e.t) begin
            failures++;
            $display("FAIL b2b_data got=%h/%h exp=%h/%h",
                     out_result, out_tag, e.r, e.t);
          end
        end
      end
      if (in_valid && in_ready) begin
        q.push_back('{golden(), in_tag});
        sent++;
      end
      @(negedge clk);
    end
    in_valid = 1'b0;
    checks++;
    if (got != N || q.size() != 0) begin
      failures++;
      $display("FAIL b2b_count got=%0d exp=%0d", got, N);
    end
    checks++;
    if (last_c - first_c != N - 1) begin
      failures++;
      $display("FAIL b2b_rate got=%0d exp=%0d", last_c - first_c, N - 1);
    end
  endtask

  task automatic test_stall();
    localparam int N = 300;
    exp_t q[$];
    exp_t e;
    int sent = 0;
    int got = 0;
    logic prev_stall = 1'b0;
    logic [W2-1:0] prev_r = '0;
    logic [TAG_W-1:0] prev_t = '0;
    for (int c = 0; c < 6 * N + 100 && (sent < N || q.size() > 0); c++) begin
      drive((sent < N) && ($urandom_range(0, 9) < 7), rnd_w(), rnd_w(),
            ADD ? {rnd_w(), rnd_w()} : Z2, 4'($urandom));
      out_ready = 1'($urandom_range(0, 1));
      #1;
      checks++;
      if (in_ready !== ~(out_valid & ~out_ready)) begin
        failures++;
        $display("FAIL stall_ready got=%b exp=%b", in_ready,
                 ~(out_valid & ~out_ready));
      end
      if (prev_stall) begin
        checks++;
        if (out_valid !== 1'b1 || out_result !== prev_r ||
            out_tag !== prev_t) begin
          failures++;
          $display("FAIL stall_hold got=%b/%h/%h exp=1/%h/%h", out_valid,
                   out_result, out_tag, prev_r, prev_t);
        end
      end
      if (out_valid && out_ready) begin
        got++;
        checks++;
        if (q.size() == 0) begin
          failures++;
          $display("FAIL stall_extra got=%h exp=none", out_result);
        end else begin
          e = q.pop_front();
          if (out_result !== e.r || out_tag !== e.t) begin
            failures++;
            $display("FAIL stall_data got=%h/%h exp=%h/%h",
                     out_result, out_tag, e.r, e.t);
          end
        end
      end
      if (in_valid && in_ready) begin
        q.push_back('{golden(), in_tag});
        sent++;
      end
      prev_stall = out_valid & ~out_ready;
      prev_r     = out_result;
      prev_t     = out_tag;
      @(negedge clk);
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    checks++;
    if (got != N || q.size() != 0) begin
      failures++;
      $display("FAIL stall_count got=%0d exp=%0d", got, N);
    end
  endtask

  task automatic test_reset_flight();
    int seen = 0;
    int n;
    out_ready = 1'b1;
    for (int k = 0; k < 5; k++) begin
      drive(1'b1, rnd_w(), rnd_w(), Z2, TAG_W'(k + 1));
      @(negedge clk);
    end
    in_valid = 1'b0;
    rst      = 1'b1;
    @(negedge clk);
    checks++;
    if (out_valid !== 1'b0 || out_result !== Z2 || out_tag !== '0) begin
      failures++;
      $display("FAIL flight_reset got=%b/%h/%h exp=0/0/0",
               out_valid, out_result, out_tag);
    end
    rst = 1'b0;
    @(negedge clk);
    checks++;
    if (in_ready !== 1'b1) begin
      failures++;
      $display("FAIL flight_ready got=%b exp=1", in_ready);
    end
    for (int c = 0; c < LAT + 4; c++) begin
      if (out_valid) seen++;
      @(negedge clk);
    end
    checks++;
    if (seen != 0) begin
      failures++;
      $display("FAIL flight_stale got=%0d exp=0", seen);
    end
    drive(1'b1, 128'h7, 128'h9, Z2, 4'hA);
    @(negedge clk);
    in_valid = 1'b0;
    n = 1;
    while (!out_valid && n < LAT + 4) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (out_valid !== 1'b1 || out_result !== 256'h3F || out_tag !== 4'hA) begin
      failures++;
      $display("FAIL flight_after got=%b/%h/%h exp=1/3f/a",
               out_valid, out_result, out_tag);
    end
    @(negedge clk);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

  initial begin
    test_reset();
    test_basic();
    test_directed();
    test_back_to_back();
    test_stall();
    test_reset_flight();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
